spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
// - SPI serial front end for the single-port SPI RAM; the RAM-facing end of the RAM's parallel command interface.
// - Deserialises MOSI frames into {cmd[1:0], payload[DATA_W-1:0]} words and pulses rx_valid per complete frame.
// - Captures the RAM read word on tx_valid and serialises it MSB-first on MISO.
// - SPI clock is the system clock clk; mosi is sampled on rising clk while ss_n is low.
// PARAMETERS
// - DATA_W   8   payload/read-data width; frame width FRAME_W = DATA_W+2 (localparam)
// PORTS
// - clk       in   1         system clock (also serial bit clock)
// - rst       in   1         asynchronous, active-high reset
// - ss_n      in   1         slave select, active low; high = idle/abort
// - mosi      in   1         serial data in, MSB first
// - miso      out  1         serial read data out, MSB first
// - rx_data   out  FRAME_W   assembled frame {cmd[1:0], payload}
// - rx_valid  out  1         1-cycle strobe, rx_data valid
// - tx_data   in   DATA_W    read word from RAM
// - tx_valid  in   1         read word strobe from RAM
// BEHAVIOUR
// - Reset (async, rst=1):
//   - Outputs: miso=0, rx_data=0, rx_valid=0.
//   - Internal: state=IDLE, bit counter=0, rd_addr_seen=0.
// - FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
//   - ss_n=1 in any state moves to IDLE next cycle (highest priority after rst).
// - IDLE -> CHK_CMD on the first cycle ss_n=0; no bit is captured in that cycle.
// - CHK_CMD samples frame bit FRAME_W-1 (cmd[1]) into the shift register, then branches:
//   - bit=0 -> WRITE
//   - bit=1 and rd_addr_seen=0 -> READ_ADD
//   - bit=1 and rd_addr_seen=1 -> READ_DATA
// - WRITE / READ_ADD / READ_DATA shift in the remaining FRAME_W-1 bits, one per cycle, MSB first.
// - Completion: the cycle after the last (FRAME_W-th) bit is sampled,
//   - rx_data = full frame and rx_valid = 1 for exactly one cycle;
//   - rx_data holds its value until the next completed frame.
// - cmd[0] (frame bit DATA_W) is forwarded unchanged; the slave does not check it against the state.
// - rd_addr_seen: set when a READ_ADD frame completes; cleared when a READ_DATA frame completes.
// - Bits after frame completion while ss_n stays low are ignored; no second rx_valid until ss_n goes high and low again.
// - READ_DATA, after rx_valid:
//   - Wait for tx_valid (RAM latency is 1 cycle, but any latency is accepted while ss_n=0).
//   - On tx_valid=1, latch tx_data.
//   - From the next cycle, drive miso with tx_data[DATA_W-1] .. tx_data[0], one bit per cycle for DATA_W cycles.
//   - After the last bit, miso returns to 0.
// - tx_valid outside the READ_DATA wait window is ignored. Only the first tx_valid per frame is used.
// - miso = 0 whenever no read word is being shifted.
// - Abort: ss_n=1 before the frame completes gives no rx_valid, clears the bit counter and leaves rd_addr_seen unchanged.
//   - If this happens during miso shifting, shifting stops and miso=0 next cycle.
// - Reset mid-frame or mid-shift is an immediate async return to the reset values; no rx_valid is emitted.
// TESTING
// - Reset: assert rst mid-frame -> miso=0, rx_valid=0, rx_data=0 immediately; the next frame decodes normally.
// - Write-address frame: ss_n=0, mosi=10'b00_1010_0101 -> one rx_valid pulse, rx_data=10'h0A5; miso stays 0.
// - Write-data frame: mosi=10'b01_0011_1100 -> rx_data=10'h13C, single rx_valid; rd_addr_seen unchanged.
// - Read sequence:
//   - Frame 10'h2F0 -> rx_valid, state READ_ADD, rd_addr_seen=1.
//   - Frame 10'h300 -> rx_valid; drive tx_valid with tx_data=8'hC3 1 cycle later.
//   - Required: miso = 1,1,0,0,0,0,1,1 on consecutive cycles, then 0; rd_addr_seen=0.
// - Abort: ss_n high after 6 bits -> no rx_valid, IDLE; a following full frame 10'h055 -> rx_data=10'h055.
// - Overlength/stray: 14 bits with ss_n low -> exactly one rx_valid; tx_valid pulse during WRITE -> miso stays 0.

Source files
------------

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pins and RAM-side parallel command/read-word signals
interface spi_slave_if #(
    parameter int DATA_W = 8
);
    logic              ss_n;
    logic              mosi;
    logic              miso;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    modport slave (
        input  ss_n, mosi, tx_data, tx_valid,
        output miso, rx_data, rx_valid
    );

    modport master (
        output ss_n, mosi, tx_data, tx_valid,
        input  miso, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI frame deserialiser and read-word serialiser for the SPI RAM
module spi_slave #(
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    spi_slave_if.slave   bus
);
    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TX_W    = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [FRAME_W-2:0]   shift;
    logic                 done;
    logic                 rd_addr_seen;
    logic                 wait_tx;
    logic [DATA_W-1:0]    tx_sh;
    logic [TX_W-1:0]      tx_cnt;
    logic                 miso_q;
    logic [FRAME_W-1:0]   rx_data_q;
    logic                 rx_valid_q;

    assign bus.miso     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            done         <= 1'b0;
            rd_addr_seen <= 1'b0;
            wait_tx      <= 1'b0;
            tx_sh        <= '0;
            tx_cnt       <= '0;
            miso_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
        end else if (bus.ss_n) begin
            // Deselect aborts everything except the captured frame and the read-phase flag
            state      <= IDLE;
            bit_cnt    <= '0;
            done       <= 1'b0;
            wait_tx    <= 1'b0;
            tx_cnt     <= '0;
            miso_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state)
                IDLE: state <= CHK_CMD;
                CHK_CMD: begin
                    shift   <= {{(FRAME_W-2){1'b0}}, bus.mosi};
                    bit_cnt <= CNT_W'(1);
                    if (!bus.mosi)        state <= WRITE;
                    else if (rd_addr_seen) state <= READ_DATA;
                    else                  state <= READ_ADD;
                end
                default: begin
                    // done latches after the last bit so overlength frames are ignored
                    if (!done) begin
                        shift   <= {shift[FRAME_W-3:0], bus.mosi};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                            rx_data_q  <= {shift, bus.mosi};
                            rx_valid_q <= 1'b1;
                            done       <= 1'b1;
                            if (state == READ_ADD) rd_addr_seen <= 1'b1;
                            if (state == READ_DATA) begin
                                rd_addr_seen <= 1'b0;
                                wait_tx      <= 1'b1;
                            end
                        end
                    end
                end
            endcase

            // tx_cnt counts bits still to present on miso, including the current one
            if (wait_tx && bus.tx_valid) begin
                wait_tx <= 1'b0;
                miso_q  <= bus.tx_data[DATA_W-1];
                tx_sh   <= {bus.tx_data[DATA_W-2:0], 1'b0};
                tx_cnt  <= TX_W'(DATA_W);
            end else if (tx_cnt > TX_W'(1)) begin
                miso_q  <= tx_sh[DATA_W-1];
                tx_sh   <= {tx_sh[DATA_W-2:0], 1'b0};
                tx_cnt  <= tx_cnt - TX_W'(1);
            end else begin
                miso_q  <= 1'b0;
                tx_cnt  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - randomized and directed bench for spi_slave against a frame-level model
module tb_spi_slave;
    localparam int DATA_W  = 8;
    localparam int FRAME_W = DATA_W + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_if #(.DATA_W(DATA_W)) bus ();
    spi_slave #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: k counts select-low cycles, bits k=1..FRAME_W form the frame
    int               m_k;
    logic [FRAME_W-1:0] m_frame, m_rx_data;
    logic             m_rx_valid, m_miso, m_seen, m_wait, m_is_rd, m_rd_phase;
    logic             mq[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k = 0; m_frame = '0; m_rx_data = '0; m_rx_valid = 0;
            m_miso = 0; m_seen = 0; m_wait = 0; m_is_rd = 0; m_rd_phase = 0;
            mq.delete();
        end else if (bus.ss_n) begin
            m_k = 0; m_frame = '0; m_rx_valid = 0; m_miso = 0; m_wait = 0;
            mq.delete();
        end else begin
            m_rx_valid = 0;
            if (m_wait && bus.tx_valid && m_k > FRAME_W) begin
                m_wait = 0;
                for (int i = DATA_W - 1; i >= 0; i--) mq.push_back(bus.tx_data[i]);
            end
            m_miso = (mq.size() > 0) ? mq.pop_front() : 1'b0;
            if (m_k >= 1 && m_k <= FRAME_W) begin
                m_frame = {m_frame[FRAME_W-2:0], bus.mosi};
                if (m_k == 1) begin
                    m_is_rd    = bus.mosi;
                    m_rd_phase = m_seen;
                end
                if (m_k == FRAME_W) begin
                    m_rx_data  = m_frame;
                    m_rx_valid = 1;
                    if (m_is_rd) begin
                        if (m_rd_phase) begin
                            m_seen = 0;
                            m_wait = 1;
                        end else begin
                            m_seen = 1;
                        end
                    end
                end
            end
            if (m_k <= FRAME_W) m_k++;
        end
    end

    // Observation of DUT outputs for the directed literal checks
    int               pulse_cnt, miso_ones, win_n = 10;
    logic [FRAME_W-1:0] last_rx;
    logic [9:0]       win;

    always @(negedge clk) begin
        if (checking) begin
            check("miso", 32'(bus.miso), 32'(m_miso));
            check("rx_valid", 32'(bus.rx_valid), 32'(m_rx_valid));
            check("rx_data", 32'(bus.rx_data), 32'(m_rx_data));
        end
        if (bus.miso === 1'b1) miso_ones++;
        if (bus.rx_valid === 1'b1) begin
            pulse_cnt++;
            last_rx = bus.rx_data;
            win_n   = 0;
        end else if (win_n < 10) begin
            win = {win[8:0], bus.miso};
            win_n++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        pulse_cnt = 0;
        miso_ones = 0;
    endtask

    task automatic drive_frame(input logic [FRAME_W-1:0] f, input int nbits, input int extra,
                               input int tx_delay, input logic [DATA_W-1:0] txw, input bit stray);
        step();
        bus.ss_n = 1'b0;
        bus.mosi = 1'($urandom);
        for (int i = 0; i < nbits; i++) begin
            step();
            bus.mosi     = (i < FRAME_W) ? f[FRAME_W-1-i] : 1'($urandom);
            bus.tx_valid = stray && ($urandom_range(0, 2) == 0);
            bus.tx_data  = DATA_W'($urandom);
        end
        for (int j = 0; j < extra; j++) begin
            step();
            bus.mosi     = 1'($urandom);
            bus.tx_valid = (j == tx_delay) || (stray && ($urandom_range(0, 3) == 0));
            bus.tx_data  = (j == tx_delay) ? txw : DATA_W'($urandom);
        end
        step();
        bus.ss_n     = 1'b1;
        bus.tx_valid = 1'b0;
        step();
    endtask

    initial begin
        bus.ss_n = 1'b1; bus.mosi = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checking = 1'b1;
        step();
        check("reset rx_data", 32'(bus.rx_data), 32'h0);
        check("reset miso", 32'(bus.miso), 32'h0);

        clear_obs();
        drive_frame(10'h0A5, FRAME_W, 3, -1, '0, 1'b0);
        check("wr_addr pulses", 32'(pulse_cnt), 32'd1);
        check("wr_addr data", 32'(last_rx), 32'h0A5);
        check("wr_addr miso", 32'(miso_ones), 32'd0);

        clear_obs();
        drive_frame(10'h13C, FRAME_W, 2, -1, '0, 1'b0);
        check("wr_data pulses", 32'(pulse_cnt), 32'd1);
        check("wr_data data", 32'(last_rx), 32'h13C);
        check("wr_data seen", 32'(m_seen), 32'd0);

        clear_obs();
        drive_frame(10'h2F0, FRAME_W, 2, -1, '0, 1'b0);
        check("rd_addr pulses", 32'(pulse_cnt), 32'd1);
        check("rd_addr data", 32'(last_rx), 32'h2F0);
        check("rd_addr seen", 32'(m_seen), 32'd1);

        clear_obs();
        drive_frame(10'h300, FRAME_W, 12, 1, 8'hC3, 1'b0);
        check("rd_data pulses", 32'(pulse_cnt), 32'd1);
        check("rd_data data", 32'(last_rx), 32'h300);
        check("rd_data miso seq", 32'(win), 32'b0110000110);
        check("rd_data seen", 32'(m_seen), 32'd0);

        clear_obs();
        drive_frame(10'h3FF, 6, 0, -1, '0, 1'b0);
        check("abort pulses", 32'(pulse_cnt), 32'd0);
        drive_frame(10'h055, FRAME_W, 2, -1, '0, 1'b0);
        check("after abort pulses", 32'(pulse_cnt), 32'd1);
        check("after abort data", 32'(last_rx), 32'h055);

        clear_obs();
        drive_frame(10'h1AA, 14, 4, -1, '0, 1'b1);
        check("overlength pulses", 32'(pulse_cnt), 32'd1);
        check("overlength data", 32'(last_rx), 32'h1AA);
        check("stray tx miso", 32'(miso_ones), 32'd0);

        // Reset in the middle of a frame while rx_data holds a nonzero frame
        step();
        bus.ss_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            bus.mosi = 1'($urandom);
        end
        rst = 1'b1;
        #1;
        check("rst rx_data", 32'(bus.rx_data), 32'h0);
        check("rst rx_valid", 32'(bus.rx_valid), 32'h0);
        check("rst miso", 32'(bus.miso), 32'h0);
        step();
        bus.ss_n = 1'b1;
        rst = 1'b0;
        step();
        clear_obs();
        drive_frame(10'h0A5, FRAME_W, 1, -1, '0, 1'b0);
        check("post rst pulses", 32'(pulse_cnt), 32'd1);
        check("post rst data", 32'(last_rx), 32'h0A5);

        for (int n = 0; n < 80; n++) begin
            int nb, ex, td;
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 14) : FRAME_W;
            ex = $urandom_range(0, 14);
            td = $urandom_range(0, 4) == 0 ? -1 : $urandom_range(0, 4);
            drive_frame(FRAME_W'($urandom), nb, ex, td, DATA_W'($urandom), 1'($urandom));
        end

        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
